// File: rtl/ula_sequencer_pkg.sv
// ula_pkg: shared types and constants for the ULA sequencer.
// Holds the FSM state encoding, the ULA opcode map and datapath widths.
package ula_pkg;

  localparam int DATA_W = 8;
  localparam int RES_W  = 9;
  localparam int CNT_W  = 4;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_SHR = 3'd7;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    EXEC = 3'd2,
    CAPT = 3'd3,
    RESP = 3'd4
  } state_t;

endpackage

// File: rtl/ula_sequencer_if.sv
// ula_sequencer_if: request/response handshakes plus the ULA register
// connections. The optional result flags exist only when ULA_SEQ_FLAGS_EN
// is defined.
interface ula_sequencer_if
  import ula_pkg::*;
#(
  parameter int OP_W = 3
);

  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;
  logic [OP_W-1:0]   req_op;
  logic [DATA_W-1:0] ula_a;
  logic [DATA_W-1:0] ula_b;
  logic [OP_W-1:0]   ula_op;
  logic [RES_W-1:0]  ula_res;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [RES_W-1:0]  rsp_data;
  logic              busy;
`ifdef ULA_SEQ_FLAGS_EN
  logic              rsp_zero;
  logic              rsp_carry;
`endif

  // Sequencer side
  modport slave (
    input  req_valid, req_a, req_b, req_op, ula_res, rsp_ready,
`ifdef ULA_SEQ_FLAGS_EN
    output rsp_zero, rsp_carry,
`endif
    output req_ready, ula_a, ula_b, ula_op, rsp_valid, rsp_data, busy
  );

  // Requester / ULA side
  modport master (
    output req_valid, req_a, req_b, req_op, ula_res, rsp_ready,
`ifdef ULA_SEQ_FLAGS_EN
    input  rsp_zero, rsp_carry,
`endif
    input  req_ready, ula_a, ula_b, ula_op, rsp_valid, rsp_data, busy
  );

endinterface

// File: rtl/ula_sequencer_cnt.sv
// ula_seq_cnt: 4-bit loadable down-counter timing the EXEC phase.
// Decrement saturates at zero so a stray dec never wraps.
module ula_seq_cnt
  import ula_pkg::*;
(
  input  logic             clk,
  input  logic             clr_n,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load has priority over decrement
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ula_sequencer.sv
// ula_sequencer: walks the ULA through IDLE->LOAD->EXEC->CAPT->RESP for
// one operation at a time. Define ULA_SEQ_FLAGS_EN to add the registered
// rsp_zero / rsp_carry result flags.
module ula_sequencer
  import ula_pkg::*;
#(
  parameter int EXEC_CYCLES = 1,
  parameter int OP_W        = 3
) (
  input logic            clk,
  input logic            clr_n,
  ula_sequencer_if.slave bus
);

  if ((EXEC_CYCLES < 1) || (EXEC_CYCLES > 15)) begin : g_bad_exec_cycles
    $error("ula_sequencer: EXEC_CYCLES must be within 1..15");
  end

  localparam logic [CNT_W-1:0] EXEC_LOAD = CNT_W'(EXEC_CYCLES - 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [RES_W-1:0]  data_q, data_d;
  logic              cnt_load;
  logic              cnt_dec;
  logic              cnt_zero;
`ifdef ULA_SEQ_FLAGS_EN
  logic              zero_q, zero_d;
  logic              carry_q, carry_d;
`endif

  ula_seq_cnt u_cnt (
    .clk       (clk),
    .clr_n     (clr_n),
    .load_i    (cnt_load),
    .dec_i     (cnt_dec),
    .load_val_i(EXEC_LOAD),
    .zero_o    (cnt_zero)
  );

  // Next-state logic: operand holding, counter control and result capture
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    data_d   = data_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
`ifdef ULA_SEQ_FLAGS_EN
    zero_d   = zero_q;
    carry_d  = carry_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          a_d     = bus.req_a;
          b_d     = bus.req_b;
          op_d    = bus.req_op;
          state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_load = 1'b1;
        state_d  = EXEC;
      end
      EXEC: begin
        if (cnt_zero) begin
          state_d = CAPT;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      CAPT: begin
        data_d  = bus.ula_res;
`ifdef ULA_SEQ_FLAGS_EN
        zero_d  = (bus.ula_res[DATA_W-1:0] == '0);
        carry_d = bus.ula_res[RES_W-1];
`endif
        state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      data_q  <= '0;
`ifdef ULA_SEQ_FLAGS_EN
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      data_q  <= data_d;
`ifdef ULA_SEQ_FLAGS_EN
      zero_q  <= zero_d;
      carry_q <= carry_d;
`endif
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_data  = data_q;
  assign bus.ula_a     = a_q;
  assign bus.ula_b     = b_q;
  assign bus.ula_op    = op_q;
`ifdef ULA_SEQ_FLAGS_EN
  assign bus.rsp_zero  = zero_q;
  assign bus.rsp_carry = carry_q;
`endif

endmodule

// File: tb/tb_ula_sequencer.sv
// tb_ula_sequencer: directed vectors against two sequencer instances
// (EXEC_CYCLES=1 and EXEC_CYCLES=5), each feeding a small ULA model built
// from an input register and an output register.
module tb_ula_sequencer;
  import ula_pkg::*;

  logic clk   = 1'b0;
  logic clr_n = 1'b0;

  always #5 clk = ~clk;

  ula_sequencer_if #(.OP_W(3)) bus0 ();
  ula_sequencer_if #(.OP_W(3)) bus5 ();

  ula_sequencer #(.EXEC_CYCLES(1), .OP_W(3)) dut0 (
    .clk  (clk),
    .clr_n(clr_n),
    .bus  (bus0)
  );

  ula_sequencer #(.EXEC_CYCLES(5), .OP_W(3)) dut5 (
    .clk  (clk),
    .clr_n(clr_n),
    .bus  (bus5)
  );

  // ULA core model
  function automatic logic [8:0] ula_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [2:0] op);
    case (op)
      OP_ADD:  return {1'b0, a} + {1'b0, b};
      OP_SUB:  return {1'b0, a} - {1'b0, b};
      OP_AND:  return {1'b0, a & b};
      OP_OR:   return {1'b0, a | b};
      OP_XOR:  return {1'b0, a ^ b};
      OP_NOT:  return {1'b0, ~a};
      OP_SHL:  return {a, 1'b0};
      default: return {1'b0, a >> 1};
    endcase
  endfunction

  logic [7:0] in0_a, in0_b, in5_a, in5_b;
  logic [2:0] in0_op, in5_op;

  // Input registers sample the sequencer outputs; output register holds the result
  always @(posedge clk) begin
    in0_a        <= bus0.ula_a;
    in0_b        <= bus0.ula_b;
    in0_op       <= bus0.ula_op;
    bus0.ula_res <= ula_f(in0_a, in0_b, in0_op);
    in5_a        <= bus5.ula_a;
    in5_b        <= bus5.ula_b;
    in5_op       <= bus5.ula_op;
    bus5.ula_res <= ula_f(in5_a, in5_b, in5_op);
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp0(output int l);
    l = 0;
    while ((bus0.rsp_valid !== 1'b1) && (l < 20)) begin
      tick();
      l++;
    end
  endtask

  task automatic wait_rsp5(output int l);
    l = 0;
    while ((bus5.rsp_valid !== 1'b1) && (l < 20)) begin
      tick();
      l++;
    end
  endtask

  int         lat;
  int         cyc;
  int         acc2;
  int         bad;
  logic [8:0] r1;

  initial begin
    bus0.req_valid = 1'b0; bus0.req_a = '0; bus0.req_b = '0; bus0.req_op = '0;
    bus0.rsp_ready = 1'b0;
    bus5.req_valid = 1'b0; bus5.req_a = '0; bus5.req_b = '0; bus5.req_op = '0;
    bus5.rsp_ready = 1'b0;

    // Reset values
    #12;
    check_vec("rst_req_ready", bus0.req_ready, 1);
    check_vec("rst_busy",      bus0.busy,      0);
    check_vec("rst_rsp_valid", bus0.rsp_valid, 0);
    check_vec("rst_rsp_data",  bus0.rsp_data,  0);
    check_vec("rst_ula_a",     bus0.ula_a,     0);
    check_vec("rst_ula_b",     bus0.ula_b,     0);
    check_vec("rst_ula_op",    bus0.ula_op,    0);
    check_vec("rst5_rsp_valid", bus5.rsp_valid, 0);
`ifdef ULA_SEQ_FLAGS_EN
    check_vec("rst_zero",  bus0.rsp_zero,  0);
    check_vec("rst_carry", bus0.rsp_carry, 0);
`endif
    tick();
    clr_n = 1'b1;
    tick();

    // ADD 200+100, request changed to 0xFF right after accept
    bus0.req_a = 8'd200; bus0.req_b = 8'd100; bus0.req_op = OP_ADD; bus0.req_valid = 1'b1;
    tick();
    bus0.req_valid = 1'b0;
    bus0.req_a     = 8'hFF;
    check_vec("add_load_ula_a", bus0.ula_a, 200);
    check_vec("add_busy",       bus0.busy,  1);
    wait_rsp0(lat);
    check_vec("add_latency",   lat,           3);
    check_vec("add_rsp_data",  bus0.rsp_data, 9'h12C);
    check_vec("add_resp_ula_a", bus0.ula_a,   200);
`ifdef ULA_SEQ_FLAGS_EN
    check_vec("add_carry", bus0.rsp_carry, 1);
    check_vec("add_zero",  bus0.rsp_zero,  0);
`endif
    bus0.rsp_ready = 1'b1;
    tick();
    bus0.rsp_ready = 1'b0;
    check_vec("add_ready_back", bus0.req_ready, 1);
    check_vec("add_idle_busy",  bus0.busy,      0);

    // EXEC_CYCLES=5, SUB 5-5
    bus5.req_a = 8'd5; bus5.req_b = 8'd5; bus5.req_op = OP_SUB; bus5.req_valid = 1'b1;
    tick();
    bus5.req_valid = 1'b0;
    wait_rsp5(lat);
    check_vec("sub5_latency",  lat,           7);
    check_vec("sub5_rsp_data", bus5.rsp_data, 0);
`ifdef ULA_SEQ_FLAGS_EN
    check_vec("sub5_zero",  bus5.rsp_zero,  1);
    check_vec("sub5_carry", bus5.rsp_carry, 0);
`endif
    bus5.rsp_ready = 1'b1;
    tick();
    bus5.rsp_ready = 1'b0;

    // Back-pressure: AND F0&3C held in RESP for 10 cycles with a competing request
    bus0.req_a = 8'hF0; bus0.req_b = 8'h3C; bus0.req_op = OP_AND; bus0.req_valid = 1'b1;
    tick();
    bus0.req_valid = 1'b0;
    wait_rsp0(lat);
    check_vec("bp_rsp_data", bus0.rsp_data, 9'h030);
    bus0.req_a = 8'h11; bus0.req_b = 8'h22; bus0.req_op = OP_ADD; bus0.req_valid = 1'b1;
    bad = 0;
    repeat (10) begin
      tick();
      if ((bus0.rsp_valid !== 1'b1) || (bus0.rsp_data !== 9'h030) || (bus0.req_ready !== 1'b0))
        bad++;
    end
    check_vec("bp_stable", bad,          0);
    check_vec("bp_ula_a",  bus0.ula_a,   8'hF0);
    check_vec("bp_ula_op", bus0.ula_op,  OP_AND);
    bus0.req_valid = 1'b0;
    bus0.rsp_ready = 1'b1;
    tick();
    bus0.rsp_ready = 1'b0;

    // Back-to-back: XOR AA^0F then OR 12|40 with req_valid held high
    bus0.rsp_ready = 1'b1;
    bus0.req_a = 8'hAA; bus0.req_b = 8'h0F; bus0.req_op = OP_XOR; bus0.req_valid = 1'b1;
    tick();
    bus0.req_a = 8'h12; bus0.req_b = 8'h40; bus0.req_op = OP_OR;
    cyc  = 0;
    acc2 = -1;
    r1   = '0;
    while ((acc2 < 0) && (cyc < 20)) begin
      if (bus0.rsp_valid === 1'b1) r1 = bus0.rsp_data;
      if (bus0.req_ready === 1'b1) acc2 = cyc + 1;
      tick();
      cyc++;
    end
    bus0.req_valid = 1'b0;
    check_vec("b2b_interval", acc2, 5);
    check_vec("b2b_rsp1",     r1,   9'h0A5);
    wait_rsp0(lat);
    check_vec("b2b_latency2", lat,           3);
    check_vec("b2b_rsp2",     bus0.rsp_data, 9'h052);
    tick();
    bus0.rsp_ready = 1'b0;

    // Reset asserted during EXEC: SUB 9-3 aborted
    bus0.req_a = 8'd9; bus0.req_b = 8'd3; bus0.req_op = OP_SUB; bus0.req_valid = 1'b1;
    tick();
    bus0.req_valid = 1'b0;
    tick();
    check_vec("abort_in_exec_busy", bus0.busy, 1);
    clr_n = 1'b0;
    #1;
    check_vec("abort_busy",      bus0.busy,      0);
    check_vec("abort_req_ready", bus0.req_ready, 1);
    check_vec("abort_ula_a",     bus0.ula_a,     0);
    check_vec("abort_rsp_data",  bus0.rsp_data,  0);
    tick();
    clr_n = 1'b1;
    bad = 0;
    repeat (6) begin
      tick();
      if (bus0.rsp_valid !== 1'b0) bad++;
    end
    check_vec("abort_no_rsp", bad, 0);

    // Next op after abort: NOT 0F
    bus0.req_a = 8'h0F; bus0.req_b = 8'h00; bus0.req_op = OP_NOT; bus0.req_valid = 1'b1;
    tick();
    bus0.req_valid = 1'b0;
    wait_rsp0(lat);
    check_vec("post_latency",  lat,           3);
    check_vec("post_rsp_data", bus0.rsp_data, 9'h0F0);
    bus0.rsp_ready = 1'b1;
    tick();
    bus0.rsp_ready = 1'b0;
    check_vec("post_idle", bus0.req_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
